// File: rtl/asic_pal_pkg.sv
// -----------------------------------------------------------------------------
// asic_pal_pkg
// Shared definitions for the ASIC palette blocks: register page base address,
// entry count, border pen index, colour and pen types, and an address decode
// helper.
// -----------------------------------------------------------------------------
package asic_pal_pkg;

  localparam logic [15:0] PAL_BASE    = 16'h6400;
  localparam int          PAL_ENTRIES = 32;
  localparam logic [4:0]  PEN_BORDER  = 5'd16;

  typedef logic [4:0] pen_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // The palette occupies one 64-byte page, so a hit is decided on addr[15:6].
  function automatic logic pal_page_hit(input logic [9:0] page);
    return (page == PAL_BASE[15:6]);
  endfunction

endpackage

// File: rtl/asic_pal_regfile.sv
// -----------------------------------------------------------------------------
// asic_pal_regfile
// 32 x 12-bit palette storage with CPU byte-write decode and a write-through
// lookup port.
//
// Ports:
//   clk_sys, reset_n      system clock, async active-low reset (clears entries)
//   plus_mode             writes are only accepted in Plus mode
//   asic_unlocked         ASIC register page mapped
//   cpu_addr/data/wr      CPU write port (even byte = {R,B}, odd byte = G)
//   rd_idx / rd_rgb       lookup port; rd_rgb already includes a write landing
//                         on rd_idx in the current cycle
//   rb_rgb                (ASIC_PAL_READBACK_EN only) entry at cpu_addr
// -----------------------------------------------------------------------------
module asic_pal_regfile
  import asic_pal_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic        asic_unlocked,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic [4:0]  rd_idx,
`ifdef ASIC_PAL_READBACK_EN
  output logic [11:0] rb_rgb,
`endif
  output logic [11:0] rd_rgb
);

  rgb12_t pal_q [PAL_ENTRIES];
  rgb12_t pal_d [PAL_ENTRIES];
  logic   wr_hit;
  pen_t   wr_idx;

  assign wr_hit = cpu_wr & asic_unlocked & plus_mode & pal_page_hit(cpu_addr[15:6]);
  assign wr_idx = cpu_addr[5:1];

  // Next-state of the storage: merge the accepted byte into its entry.
  always_comb begin
    pal_d = pal_q;
    if (wr_hit) begin
      if (cpu_addr[0]) begin
        pal_d[wr_idx].g = cpu_data[3:0];
      end else begin
        pal_d[wr_idx].r = cpu_data[7:4];
        pal_d[wr_idx].b = cpu_data[3:0];
      end
    end else begin
      pal_d = pal_q;
    end
  end

  // Palette storage registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= rgb12_t'(12'h000);
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  // Reading the next-state array gives the write-through bypass for free,
  // merged per byte exactly as the storage will be.
  assign rd_rgb = pal_d[rd_idx];

`ifdef ASIC_PAL_READBACK_EN
  assign rb_rgb = pal_q[cpu_addr[5:1]];
`endif

endmodule

// File: rtl/asic_palette_stage.sv
// -----------------------------------------------------------------------------
// asic_palette_stage
// Plus-mode palette lookup: 2-stage pixel pipeline (pen/blank sample, colour
// register) in front of the video output stage, plus CPU palette writes and
// optional readback.
//
// Optional feature macro: ASIC_PAL_READBACK_EN
//   defined   -> in-range cpu_rd (asic_unlocked=1) returns the byte one cycle
//                later on cpu_dout with cpu_dout_oe=1 for one cycle.
//   undefined -> cpu_dout=0, cpu_dout_oe=0, no readback logic.
//
// Ports:
//   clk_sys, reset_n           system clock, async active-low reset
//   plus_mode                  Plus palette enable
//   pix_en, pix_pen, pix_blank pixel sample strobe, pen index, blank qualifier
//   cpu_addr, cpu_data         CPU address / write data
//   cpu_wr, cpu_rd             single-cycle CPU strobes
//   asic_unlocked              ASIC register page mapped
//   cpu_dout, cpu_dout_oe      palette readback data / valid
//   r_out, g_out, b_out        colour to the video output stage
//   pix_valid                  one-cycle strobe for an updated colour
// -----------------------------------------------------------------------------
module asic_palette_stage
  import asic_pal_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic        pix_en,
  input  logic [4:0]  pix_pen,
  input  logic        pix_blank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        asic_unlocked,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_oe,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        pix_valid
);

  pen_t   pen_q, pen_d;
  logic   blank_q, blank_d;
  logic   s1_valid_q, s1_valid_d;
  rgb12_t rgb_q, rgb_d;
  logic   pix_valid_q, pix_valid_d;
  rgb12_t lut_rgb;

`ifdef ASIC_PAL_READBACK_EN
  rgb12_t     rb_rgb;
  logic       rb_hit;
  logic [7:0] dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;
`endif

  asic_pal_regfile u_regfile (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .plus_mode     (plus_mode),
    .asic_unlocked (asic_unlocked),
    .cpu_addr      (cpu_addr),
    .cpu_data      (cpu_data),
    .cpu_wr        (cpu_wr),
    .rd_idx        (pen_q),
`ifdef ASIC_PAL_READBACK_EN
    .rb_rgb        (rb_rgb),
`endif
    .rd_rgb        (lut_rgb)
  );

  // Pipeline next-state: stage 1 samples pen/blank, stage 2 forms the colour.
  always_comb begin
    pen_d       = pen_q;
    blank_d     = blank_q;
    s1_valid_d  = pix_en;
    rgb_d       = rgb_q;
    pix_valid_d = s1_valid_q;
    if (pix_en) begin
      pen_d   = pix_pen;
      blank_d = pix_blank;
    end else begin
      pen_d   = pen_q;
      blank_d = blank_q;
    end
    // plus_mode is looked at in the stage-2 cycle, not when the pen was sampled.
    if (s1_valid_q) begin
      if (blank_q || !plus_mode) begin
        rgb_d = rgb12_t'(12'h000);
      end else begin
        rgb_d = lut_rgb;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  // Pipeline registers; reset drops any pixel in flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pen_q       <= 5'd0;
      blank_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      rgb_q       <= rgb12_t'(12'h000);
      pix_valid_q <= 1'b0;
    end else begin
      pen_q       <= pen_d;
      blank_q     <= blank_d;
      s1_valid_q  <= s1_valid_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign pix_valid = pix_valid_q;

`ifdef ASIC_PAL_READBACK_EN
  assign rb_hit = cpu_rd & asic_unlocked & pal_page_hit(cpu_addr[15:6]);

  // Readback next-state: format the addressed byte, zero otherwise.
  always_comb begin
    dout_d    = 8'h00;
    dout_oe_d = rb_hit;
    if (rb_hit) begin
      if (cpu_addr[0]) begin
        dout_d = {4'h0, rb_rgb.g};
      end else begin
        dout_d = {rb_rgb.r, rb_rgb.b};
      end
    end else begin
      dout_d = 8'h00;
    end
  end

  // Readback output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= 8'h00;
      dout_oe_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
    end
  end

  assign cpu_dout    = dout_q;
  assign cpu_dout_oe = dout_oe_q;
`else
  logic unused_cpu_rd;
  assign unused_cpu_rd = cpu_rd;
  assign cpu_dout      = 8'h00;
  assign cpu_dout_oe   = 1'b0;
`endif

endmodule
